// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, line-locked sharing of one UART transmitter among NREQ byte producers.
//   clk, rst_n            clock and asynchronous active-low reset
//   req_valid/data/last   per-requester byte stream (byte i at req_data[8i+7:8i])
//   req_ack               one-cycle pulse when requester i's byte is taken
//   grant                 one-hot owner of the line lock, 0 when idle
//   tx_data/tx_start      byte and start pulse to the UART; tx_busy back from it
//   busy                  arbiter is not idle
//   timeout_err           pulse when a stalled owner loses the lock
module uart_tx_arbiter #(
  parameter int NREQ         = 3,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              timeout_err
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD_TIMEOUT);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;
  state_t          state_q, state_d;
  logic [IW-1:0]   g_q, g_d, rr_q, rr_d, pick, g_nxt;
  logic [NREQ-1:0] grant_q, grant_d, ack_q, ack_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            last_q, last_d, tx_start_q, tx_start_d, to_q, to_d, busy_q, busy_d;

  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] b, input int k);
    int j;
    j = int'(b) + k;
    return IW'(j >= NREQ ? j - NREQ : j);
  endfunction

  // Scan downward so the closest requester at or after rr_q wins.
  always_comb begin
    pick = rr_q;
    for (int k = NREQ - 1; k >= 0; k--)
      pick = req_valid[wrap(rr_q, k)] ? wrap(rr_q, k) : pick;
  end

  assign g_nxt  = wrap(g_q, 1);
  assign busy_d = state_d != IDLE;

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    tx_data_d  = tx_data_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    to_d       = 1'b0;
    case (state_q)
      IDLE: if (|req_valid) begin
        g_d     = pick;
        grant_d = NREQ'(1) << pick;
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: if (req_valid[g_q]) begin
        tx_data_d  = req_data[{g_q, 3'b000} +: 8];
        tx_start_d = 1'b1;
        ack_d[g_q] = 1'b1;
        last_d     = req_last[g_q];
        cnt_d      = '0;
        state_d    = WAIT_HI;
      end else if (cnt_q == CW'(HOLD_TIMEOUT - 1)) begin
        to_d    = 1'b1;
        grant_d = '0;
        rr_d    = g_nxt;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      WAIT_HI: state_d = tx_busy ? WAIT_LO : WAIT_HI;
      WAIT_LO: if (!tx_busy) begin
        state_d = last_q ? IDLE : SEND;
        grant_d = last_q ? '0 : grant_q;
        rr_d    = last_q ? g_nxt : rr_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      g_q        <= '0;
      rr_q       <= '0;
      grant_q    <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      to_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      tx_data_q  <= tx_data_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      to_q       <= to_d;
      busy_q     <= busy_d;
    end
  end

  assign req_ack     = ack_q;
  assign grant       = grant_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign busy        = busy_q;
  assign timeout_err = to_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter with requester queues and a UART busy model
module tb_uart_tx_arbiter;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] req_valid, req_last, req_ack, grant;
  logic [8*N-1:0] req_data;
  logic [7:0] tx_data;
  logic tx_start, tx_busy, busy, timeout_err;
  int checks = 0, errors = 0;
  logic [8:0] q[N][$];
  logic [8:0] mq[N][$];
  logic [N-1:0] en;
  logic [13:0] ev[$];
  logic [N-1:0] ghist[$];
  logic [N-1:0] gprev;
  int cyc = 0, fall_cyc = -1, to_cyc = -1, to_n = 0, bcnt = 0, blen = 10, mrr = 0;
  bit rnd = 1'b0, prev_busy = 1'b0;

  typedef struct {
    logic [2:0] mask;
    logic [7:0] base;
    int         n;
    logic [5:0] ord;
  } vec_t;
  vec_t tbl[7];

  uart_tx_arbiter #(.NREQ(N), .HOLD_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ack(req_ack), .grant(grant), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) bcnt <= 0;
    else if (tx_start) bcnt <= rnd ? int'($urandom_range(1, 12)) : blen;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  assign tx_busy = bcnt != 0;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  task automatic drive();
    logic [8:0] h;
    for (int i = 0; i < N; i++) begin
      h = q[i].size() > 0 ? q[i][0] : 9'h000;
      req_valid[i]       = en[i] && q[i].size() > 0;
      req_data[8*i +: 8] = h[7:0];
      req_last[i]        = h[8];
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    q[i].push_back({l, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (grant !== gprev) begin ghist.push_back(grant); gprev = grant; end
    if (timeout_err) begin to_n++; to_cyc = cyc; end
    if (tx_start || |req_ack) chk("ack_with_start", $countones(req_ack), tx_start);
    if (tx_start) begin
      chk("start_while_busy", tx_busy, 1'b0);
      ev.push_back({req_ack, grant, tx_data});
    end
    for (int i = 0; i < N; i++)
      if (req_ack[i] && q[i].size() > 0) void'(q[i].pop_front());
    if (prev_busy && !tx_busy) fall_cyc = cyc;
    prev_busy = tx_busy;
    drive();
  endtask

  task automatic wait_ev(input int n);
    int c;
    c = 0;
    while (ev.size() < n && c < 3000) begin step(); c++; end
    chk("ev_wait", ev.size() >= n, 1'b1);
  endtask

  task automatic wait_done(input int n);
    int c;
    c = 0;
    while (!(ev.size() >= n && !busy && grant == '0) && c < 5000) begin step(); c++; end
    chk("done_wait", c < 5000, 1'b1);
    chk("ev_count", ev.size(), n);
  endtask

  task automatic expect_ev(input string name, input int k, input int idx, input logic [7:0] d);
    logic [13:0] e;
    if (k < ev.size()) begin
      e = ev[k];
      chk({name, "_ack"}, e[13:11], 32'(1) << idx);
      chk({name, "_grant"}, e[10:8], 32'(1) << idx);
      chk({name, "_data"}, e[7:0], d);
    end else begin
      chk({name, "_missing"}, ev.size(), k + 1);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_ack"}, req_ack, 0);
    chk({tag, "_start"}, tx_start, 0);
    chk({tag, "_data"}, tx_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_toerr"}, timeout_err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin q[i].delete(); en[i] = 1'b0; end
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_busy = 1'b0;
    gprev = '0;
    ghist.delete();
    ev.delete();
  endtask

  function automatic int mpend();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += mq[i].size();
    return s;
  endfunction

  function automatic logic [5:0] o(input int a, input int b, input int c);
    return {2'(c), 2'(b), 2'(a)};
  endfunction

  initial begin
    tbl[0] = '{3'b011, 8'h60, 2, o(1, 0, 0)};
    tbl[1] = '{3'b111, 8'h70, 3, o(1, 2, 0)};
    tbl[2] = '{3'b101, 8'h80, 2, o(2, 0, 0)};
    tbl[3] = '{3'b001, 8'h90, 1, o(0, 0, 0)};
    tbl[4] = '{3'b100, 8'hA0, 1, o(2, 0, 0)};
    tbl[5] = '{3'b110, 8'hB0, 2, o(1, 2, 0)};
    tbl[6] = '{3'b111, 8'hC0, 3, o(0, 1, 2)};
    rst_n = 1'b0;
    en = '0;
    gprev = '0;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    // single line with latency check; leaves rr at 1
    push(0, 8'h31, 1'b0); push(0, 8'h32, 1'b0); push(0, 8'h0A, 1'b1);
    en[0] = 1'b1;
    drive();
    step();
    chk("lat_grant", grant, 3'b001);
    chk("lat_nostart", tx_start, 1'b0);
    step();
    chk("lat_start", tx_start, 1'b1);
    chk("lat_ack", req_ack, 3'b001);
    wait_done(3);
    expect_ev("single0", 0, 0, 8'h31);
    expect_ev("single1", 1, 0, 8'h32);
    expect_ev("single2", 2, 0, 8'h0A);
    chk("single_idle_grant", grant, 0);

    // table of 1-byte lines; orders derived from rr continuing at 1
    for (int v = 0; v < 7; v++) begin
      ev.delete();
      for (int i = 0; i < N; i++)
        if (tbl[v].mask[i]) begin push(i, 8'(tbl[v].base + 8'(i)), 1'b1); en[i] = 1'b1; end
      drive();
      wait_done(tbl[v].n);
      for (int k = 0; k < tbl[v].n; k++)
        expect_ev($sformatf("tbl%0d_%0d", v, k), k, int'(tbl[v].ord[2*k +: 2]),
                  8'(tbl[v].base + 8'(tbl[v].ord[2*k +: 2])));
    end

    // simultaneous after reset
    do_reset();
    push(0, 8'h11, 1'b1); push(1, 8'h22, 1'b1);
    en = 3'b011;
    drive();
    wait_done(2);
    expect_ev("simul0", 0, 0, 8'h11);
    expect_ev("simul1", 1, 1, 8'h22);
    chk("simul_ghist_n", ghist.size(), 4);
    chk("simul_gh0", ghist[0], 3'b001);
    chk("simul_gh1", ghist[1], 3'b000);
    chk("simul_gh2", ghist[2], 3'b010);

    // lock hold: req1 arrives mid-line and waits for the 0x0A
    ev.delete();
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h0A, 1'b1);
    push(1, 8'h77, 1'b1);
    en = 3'b001;
    drive();
    wait_ev(1);
    en[1] = 1'b1;
    drive();
    wait_done(4);
    expect_ev("lock0", 0, 0, 8'h41);
    expect_ev("lock1", 1, 0, 8'h42);
    expect_ev("lock2", 2, 0, 8'h0A);
    expect_ev("lock3", 3, 1, 8'h77);

    // round-robin wrap from rr=0
    do_reset();
    for (int i = 0; i < N; i++) begin
      push(i, 8'(16 * (i + 1)), 1'b1);
      push(i, 8'(16 * (i + 1) + 1), 1'b1);
      en[i] = 1'b1;
    end
    drive();
    wait_done(6);
    for (int k = 0; k < 6; k++)
      expect_ev($sformatf("rr%0d", k), k, k % 3, 8'(16 * (k % 3 + 1) + k / 3));

    // hold timeout: req2 stalls after a non-last byte, req0 waits
    ev.delete();
    to_n = 0;
    fall_cyc = -1;
    push(2, 8'h55, 1'b0);
    en = 3'b100;
    drive();
    wait_ev(1);
    push(0, 8'h66, 1'b1);
    en[0] = 1'b1;
    drive();
    for (int c = 0; c < 200 && to_n == 0; c++) step();
    chk("to_seen", to_n, 1);
    chk("to_gap", to_cyc - fall_cyc, 17);
    chk("to_grant", grant, 0);
    step();
    chk("to_pulse_len", timeout_err, 1'b0);
    wait_done(2);
    expect_ev("to_req0", 1, 0, 8'h66);
    chk("to_count", to_n, 1);

    // move rr to 2, then reset in the middle of a req0 line
    ev.delete();
    push(1, 8'h88, 1'b1);
    en = 3'b011;
    drive();
    wait_done(1);
    expect_ev("pre_rst", 0, 1, 8'h88);
    ev.delete();
    push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b0); push(0, 8'h0A, 1'b1);
    en = 3'b001;
    drive();
    wait_ev(1);
    for (int c = 0; c < 50 && !tx_busy; c++) step();
    step();
    step();
    chk("midrst_busy_before", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    q[0].delete();
    en = 3'b110;
    push(1, 8'h91, 1'b1); push(2, 8'h92, 1'b1);
    drive();
    ev.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_busy = 1'b0;
    gprev = grant;
    wait_done(2);
    expect_ev("postrst0", 0, 1, 8'h91);
    expect_ev("postrst1", 1, 2, 8'h92);

    // randomized lines against a queue-level round-robin model
    do_reset();
    rnd = 1'b1;
    mrr = 0;
    for (int r = 0; r < 3; r++) begin
      logic [9:0] xq[$];
      int tot, nl, len, p;
      logic [8:0] w;
      xq.delete();
      tot = 0;
      ev.delete();
      for (int i = 0; i < N; i++) begin
        nl = $urandom_range(0, 3);
        if (i == N - 1 && tot == 0) nl = 1;
        for (int l = 0; l < nl; l++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            w = {b == len - 1, 8'($urandom)};
            q[i].push_back(w);
            mq[i].push_back(w);
            tot++;
          end
        end
        en[i] = 1'b1;
      end
      drive();
      while (mpend() > 0) begin
        p = -1;
        for (int k = 0; k < N; k++)
          if (p < 0 && mq[(mrr + k) % N].size() > 0) p = (mrr + k) % N;
        do begin
          w = mq[p].pop_front();
          xq.push_back({2'(p), w[7:0]});
        end while (!w[8]);
        mrr = (p + 1) % N;
      end
      wait_done(xq.size());
      for (int k = 0; k < xq.size(); k++)
        expect_ev($sformatf("rnd%0d_%0d", r, k), k, int'(xq[k][9:8]), xq[k][7:0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
